// File: rtl/lane_arb_pkg.sv
// Shared types and default sizing for the lane arbiter slice.
package lane_arb_pkg;
  localparam int N_DEF         = 4;
  localparam int W_DEF         = 8;
  localparam int MAX_BEATS_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  // Scan from farthest to nearest so the lane closest to ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/lane_arbiter.sv
// N-lane burst arbiter: round-robin grant held for a whole burst, one
// registered output stage, forced termination after MAX_BEATS beats.
module lane_arbiter
  import lane_arb_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err_overrun
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BEATS + 1);

  state_t        r_state, w_next;
  logic [IW-1:0] r_gnt, r_rr_ptr, w_pick_idx, w_next_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_pick_found, w_can_acc, w_xfer, w_cap, w_last;
  logic          r_out_valid, r_out_last, r_err;
  logic [W-1:0]  r_out_data;
  logic [IW-1:0] r_out_src;

  rr_pick #(.N(N)) u_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  assign w_can_acc  = !r_out_valid || out_ready;
  assign w_xfer     = (r_state == BURST) && req_valid[r_gnt] && w_can_acc;
  assign w_cap      = (r_cnt == CW'(MAX_BEATS - 1));
  assign w_last     = req_last[r_gnt] || w_cap;
  assign w_next_ptr = (r_gnt == IW'(N - 1)) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_found)    w_next = BURST;
      BURST:   if (w_xfer && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (r_state == BURST) begin
      busy             = 1'b1;
      req_ready[r_gnt] = w_can_acc;
    end
  end

  // Grant is only reloaded from IDLE, so a lane dropping valid mid-burst keeps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == IDLE && w_pick_found) begin
        r_gnt <= w_pick_idx;
        r_cnt <= '0;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_rr_ptr <= w_next_ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_xfer && w_cap && !req_last[r_gnt];
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= req_data[r_gnt*W +: W];
        r_out_last  <= w_last;
        r_out_src   <= r_gnt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_src     = r_out_src;
  assign err_overrun = r_err;
endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter: per-cycle compare against a behavioural
// model plus hand-computed expectations on the accepted output beat stream.
module tb_lane_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0]   req_data = '0;
  logic             out_valid, out_last, busy, err_overrun;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic [1:0]       out_src;

  always #5 clk = ~clk;

  lane_arbiter #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .err_overrun(err_overrun)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Per-lane beat sources
  int           src_len[N], src_pos[N];
  logic [W-1:0] src_d[N][64];
  bit           src_l[N][64];

  task automatic push_beat(input int l, input logic [W-1:0] d, input bit last);
    src_d[l][src_len[l]] = d;
    src_l[l][src_len[l]] = last;
    src_len[l]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_pos[i] = 0; end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit v;
      v = src_pos[i] < src_len[i];
      req_valid[i]       = v;
      req_data[i*W +: W] = v ? src_d[i][src_pos[i]] : '0;
      req_last[i]        = v && src_l[i][src_pos[i]];
    end
  endtask

  // Behavioural model: post-edge view of the arbiter
  bit           m_busy, m_ov, m_ol, m_err;
  int           m_gnt, m_ptr, m_cnt, m_os;
  logic [W-1:0] m_od;

  task automatic model_reset();
    m_busy = 0; m_ov = 0; m_ol = 0; m_err = 0;
    m_gnt = 0; m_ptr = 0; m_cnt = 0; m_os = 0; m_od = '0;
  endtask

  task automatic model_step(output int pop_l);
    pop_l = -1;
    if (rst) begin model_reset(); return; end
    if (!m_busy) begin
      m_err = 0;
      if (out_ready) m_ov = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin m_busy = 1; m_gnt = j; m_cnt = 0; break; end
      end
    end else if (req_valid[m_gnt] && (!m_ov || out_ready)) begin
      m_cnt++;
      pop_l = m_gnt;
      m_ov  = 1;
      m_od  = req_data[m_gnt*W +: W];
      m_os  = m_gnt;
      m_ol  = req_last[m_gnt] || (m_cnt == MB);
      m_err = !req_last[m_gnt] && (m_cnt == MB);
      if (m_ol) begin m_busy = 0; m_ptr = (m_gnt + 1) % N; end
    end else begin
      m_err = 0;
      if (out_ready) m_ov = 0;
    end
  endtask

  // Per-cycle compare of DUT outputs against the model
  logic [N-1:0] exp_rdy;
  always @(negedge clk) begin
    exp_rdy = (m_busy && (!m_ov || out_ready)) ? (N'(1) << m_gnt) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("err_overrun", 32'(err_overrun), 32'(m_err));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_last", 32'(out_last), 32'(m_ol));
      chk("out_src", 32'(out_src), 32'(m_os));
    end
  end

  // Log of beats accepted by the sink, observed on the DUT
  typedef struct { int src; int data; bit last; int c; } beat_t;
  beat_t log_q[$];
  int    cyc_n = 0, n_err_pulse = 0;

  task automatic cyc(input bit rdy);
    int pl;
    out_ready = rdy;
    drive();
    if (out_valid && out_ready)
      log_q.push_back('{int'(out_src), int'(out_data), out_last, cyc_n});
    if (err_overrun) n_err_pulse++;
    model_step(pl);
    @(posedge clk);
    if (pl >= 0) src_pos[pl]++;
    @(negedge clk); #1;
    cyc_n++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    clear_src();
    cyc(1'b1); cyc(1'b1);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic chk_log(input int i, input int s, input int d, input bit l);
    if (i >= log_q.size()) chk($sformatf("log_len@%0d", i), 32'(log_q.size()), 32'(i + 1));
    else begin
      chk($sformatf("log_src[%0d]", i), 32'(log_q[i].src), 32'(s));
      chk($sformatf("log_data[%0d]", i), 32'(log_q[i].data), 32'(d));
      chk($sformatf("log_last[%0d]", i), 32'(log_q[i].last), 32'(l));
    end
  endtask

  initial begin
    model_reset();
    clear_src();
    drive();
    @(negedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();

    // Single lane 2 burst, then rr_ptr=3 makes lane 3 beat lane 0
    push_beat(2, 8'h11, 0); push_beat(2, 8'h22, 0); push_beat(2, 8'h33, 1);
    run(6);
    chk("t1_len", 32'(log_q.size()), 3);
    chk_log(0, 2, 8'h11, 0); chk_log(1, 2, 8'h22, 0); chk_log(2, 2, 8'h33, 1);
    log_q.delete();
    push_beat(0, 8'h05, 1); push_beat(3, 8'h3C, 1);
    run(8);
    chk("t1b_len", 32'(log_q.size()), 2);
    chk_log(0, 3, 8'h3C, 1); chk_log(1, 0, 8'h05, 1);

    // All lanes valid with 1-beat bursts: strict rotation, one idle cycle apart
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < N; l++) push_beat(l, 8'(l * 16 + b), 1);
    run(20);
    chk("t2_len", 32'(log_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_log(i, i % 4, (i % 4) * 16 + i / 4, 1);
    for (int i = 0; i + 1 < log_q.size(); i++)
      chk($sformatf("t2_gap[%0d]", i), 32'(log_q[i+1].c - log_q[i].c), 2);

    // Backpressure for 5 cycles mid-burst
    log_q.delete();
    push_beat(0, 8'hA0, 0); push_beat(0, 8'hA1, 0);
    push_beat(0, 8'hA2, 0); push_beat(0, 8'hA3, 1);
    run(3);
    repeat (5) cyc(1'b0);
    chk("t3_hold_data", 32'(out_data), 32'h A1);
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_ready", 32'(req_ready), 0);
    run(6);
    chk("t3_len", 32'(log_q.size()), 4);
    for (int i = 0; i < 4; i++) chk_log(i, 0, 8'hA0 + i, i == 3);

    // Overrun: 20 beats, last only on the 20th
    log_q.delete();
    n_err_pulse = 0;
    for (int k = 0; k < 20; k++) push_beat(1, 8'(8'h40 + k), k == 19);
    run(28);
    chk("t4_len", 32'(log_q.size()), 20);
    chk("t4_err_pulses", 32'(n_err_pulse), 1);
    for (int k = 0; k < 20; k++) chk_log(k, 1, 8'h40 + k, (k == 15) || (k == 19));

    // Asynchronous reset after beat 2 of a 4-beat burst
    do_reset();
    push_beat(2, 8'h61, 0); push_beat(2, 8'h62, 0);
    push_beat(2, 8'h63, 0); push_beat(2, 8'h64, 1);
    run(3);
    chk("t5_pre_data", 32'(out_data), 32'h62);
    chk("t5_pre_busy", 32'(busy), 1);
    chk("t5_pre_len", 32'(log_q.size()), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_data", 32'(out_data), 0);
    chk("t5_async_last", 32'(out_last), 0);
    chk("t5_async_src", 32'(out_src), 0);
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_err", 32'(err_overrun), 0);
    chk("t5_async_ready", 32'(req_ready), 0);
    model_reset();
    log_q.delete();
    @(negedge clk); #1;
    push_beat(1, 8'h77, 1);
    cyc(1'b1);
    rst = 1'b0;
    run(10);
    chk("t5_len", 32'(log_q.size()), 3);
    chk_log(0, 1, 8'h77, 1); chk_log(1, 2, 8'h63, 0); chk_log(2, 2, 8'h64, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requester lanes.
REQ-002 The block SHALL have parameter W, default 8, giving the data width per lane.
REQ-003 The block SHALL have parameter MAX_BEATS, default 16, giving the burst length limit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, N bits: per-lane beat valid.
REQ-007 The block SHALL have port req_data, input, N*W bits: lane i occupies bits [i*W +: W].
REQ-008 The block SHALL have port req_last, input, N bits: per-lane final beat of a burst.
REQ-009 The block SHALL have port req_ready, output, N bits: per-lane beat accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit: shared sink beat valid.
REQ-011 The block SHALL have port out_data, output, W bits: shared sink data.
REQ-012 The block SHALL have port out_last, output, 1 bit: shared sink last beat.
REQ-013 The block SHALL have port out_src, output, $clog2(N) bits: lane index of the current out beat.
REQ-014 The block SHALL have port out_ready, input, 1 bit: shared sink accept.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the FSM is in BURST.
REQ-016 The block SHALL have port err_overrun, output, 1 bit: one-cycle pulse on a forced burst termination.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and BURST, with a registered grant index gnt and a round-robin pointer rr_ptr.
REQ-018 In IDLE with any req_valid set, the FSM SHALL select the first valid lane at or after rr_ptr (wrapping N-1 to 0), load gnt with it, and enter BURST on the next edge.
REQ-019 In IDLE, req_ready SHALL be all zero.
REQ-020 In BURST, req_ready[gnt] SHALL equal (!out_valid || out_ready); every other req_ready bit SHALL be 0. This is a combinational function of registered state and out_ready.
REQ-021 A beat SHALL transfer when req_valid[gnt] && req_ready[gnt]. It SHALL appear registered on out_data, out_last and out_src with out_valid=1 on the following edge (latency 1).
REQ-022 out_valid SHALL clear on an edge where out_ready=1 and no new beat transfers; it SHALL hold its data stable while out_ready=0.
REQ-023 The grant SHALL be locked for the whole burst: deassertion of req_valid[gnt] mid-burst SHALL NOT release it.
REQ-024 On transfer of a beat with req_last=1, the FSM SHALL return to IDLE and set rr_ptr to (gnt+1) mod N, leaving one idle cycle between bursts.
REQ-025 A beat counter SHALL count transfers in BURST. When the MAX_BEATS-th beat transfers without req_last, the FSM SHALL:
- force out_last=1 on that beat,
- pulse err_overrun for one cycle,
- return to IDLE,
- advance rr_ptr as in REQ-024.
REQ-026 When a single lane is valid, it SHALL win regardless of rr_ptr.
REQ-027 When all lanes are valid continuously, grants SHALL rotate 0,1,...,N-1,0.
REQ-028 Handshake SHALL be lossless: no beat is duplicated or dropped under any out_ready pattern.

Reset
REQ-029 While rst is high, the block SHALL hold:
- state=IDLE, gnt=0, rr_ptr=0, beat counter=0,
- out_valid=0, out_data=0, out_last=0, out_src=0,
- busy=0, err_overrun=0, req_ready=0.
REQ-030 Assertion of rst mid-burst SHALL discard the burst and the held output beat immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, arbitration SHALL restart from lane 0 priority.

Structure
REQ-032 A shared package lane_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default N, W and MAX_BEATS constants.
REQ-033 Round-robin selection SHALL be one combinational sub-module rr_pick with:
- inputs req[N-1:0] and ptr,
- outputs found and idx.

Verification
REQ-034 Single lane: N=4, lane 2 sends 3 beats 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out shows the same values with out_src=2 one cycle after each transfer, out_last on 0x33, rr_ptr=3.
REQ-035 All four lanes valid, each sending 1-beat bursts, after reset -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-036 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data held, req_ready[gnt]=0, no beat lost or duplicated after release.
REQ-037 Overrun: MAX_BEATS=16, lane 1 sends 20 beats without last -> beat 16 carries out_last=1, err_overrun pulses once, lane 1 is re-arbitrated afterwards.
REQ-038 Reset mid-burst: rst asserted after beat 2 of a 4-beat burst -> all outputs go to 0 asynchronously, and the next grant after reset goes to the lowest valid lane.
